// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e   : sequencing states common to serial adder/subtractor engines
//   cnt_width : width of a bit counter able to hold 0..w without wrapping
package serial_arith_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
//   a_i, b_i : operand bits
//   bin_i    : borrow in
//   d_o      : difference bit
//   bout_o   : borrow out
module full_sub (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = a_i ^ b_i ^ bin_i;
   assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: captures a and b on an accepted start, computes a - b LSB-first,
// one bit per clock through a single full_sub cell, then registers the difference, final
// borrow and signed overflow together with a one-cycle done pulse.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start_i    : request, sampled only while idle
//   a_i, b_i   : minuend / subtrahend, captured on the accepted start edge
//   busy_o     : high whenever an operation is in flight (RUN or DONE)
//   done_o     : one-cycle completion pulse
//   diff_o     : a - b mod 2^W
//   borrow_o   : 1 iff unsigned a < b
//   ovf_o      : signed overflow of a - b
module serial_sub
   import serial_arith_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] diff_o,
   output logic         borrow_o,
   output logic         ovf_o
);

   localparam int unsigned CW = cnt_width(W);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   part_q, part_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           bin_q, bin_d;
   logic           sa_q, sa_d;
   logic           sb_q, sb_d;
   logic [W-1:0]   diff_q, diff_d;
   logic           borrow_q, borrow_d;
   logic           ovf_q, ovf_d;

   logic           cell_d;
   logic           cell_bout;

   full_sub u_full_sub (
      .a_i    (a_q[0]),
      .b_i    (b_q[0]),
      .bin_i  (bin_q),
      .d_o    (cell_d),
      .bout_o (cell_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         part_q   <= '0;
         cnt_q    <= '0;
         bin_q    <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         part_q   <= part_d;
         cnt_q    <= cnt_d;
         bin_q    <= bin_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      part_d   = part_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               part_d  = '0;
               cnt_d   = '0;
               bin_d   = 1'b0;
               sa_d    = a_i[W-1];
               sb_d    = b_i[W-1];
               state_d = StRun;
            end
         end
         StRun: begin
            a_d    = {1'b0, a_q[W-1:1]};
            b_d    = {1'b0, b_q[W-1:1]};
            part_d = {cell_d, part_q[W-1:1]};
            bin_d  = cell_bout;
            cnt_d  = cnt_q + CW'(1);
            // Last bit: publish everything at once so no partial result is ever visible.
            if (cnt_q == CW'(W - 1)) begin
               diff_d   = {cell_d, part_q[W-1:1]};
               borrow_d = cell_bout;
               // cell_d is the MSB of the difference here.
               ovf_d    = (sa_q ^ sb_q) & (sa_q ^ cell_d);
               state_d  = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy_o   = (state_q != StIdle);
   assign done_o   = (state_q == StDone);
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;
   assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   serial_sub #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .diff_o   (diff),
      .borrow_o (borrow),
      .ovf_o    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation and wait (bounded) for done. Caller is aligned 1 time unit after
   // a rising edge. lat counts edges after E0 until done is seen; returns one edge past done.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, output logic [7:0] od,
                        output logic ob, output logic oo, output int lat);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      od = diff;
      ob = borrow;
      oo = ovf;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      checks++;
      if ({busy, done, diff, borrow, ovf} !== 12'h000) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
                  busy, done, diff, borrow, ovf);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int busy_cnt;
      int lat;
      start = 1'b1;
      a     = 8'h5A;
      b     = 8'h3C;
      @(posedge clk); #1;
      start    = 1'b0;
      busy_cnt = 0;
      lat      = 0;
      while (busy && busy_cnt < 40) begin
         if (done) begin
            checks++;
            if (lat !== W) begin
               errors++;
               $display("FAIL basic_latency: done after %0d edges, want %0d", lat, W);
            end
            checks++;
            if ({diff, borrow, ovf} !== {8'h1E, 1'b0, 1'b0}) begin
               errors++;
               $display("FAIL basic_result: got diff=%h borrow=%b ovf=%b, want 1e 0 0",
                        diff, borrow, ovf);
            end
         end
         busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      // RUN for W cycles plus the DONE cycle.
      checks++;
      if (busy_cnt !== W + 1) begin
         errors++;
         $display("FAIL basic_busy_len: busy %0d cycles, want %0d", busy_cnt, W + 1);
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: done=%b after idle, want 0", done);
      end
   endtask

   task automatic test_wrap_ovf();
      logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h80, 8'h7F};
      logic [7:0] vb [4] = '{8'h01, 8'hFF, 8'h01, 8'hFF};
      logic [7:0] ed [4] = '{8'hFF, 8'h00, 8'h7F, 8'h80};
      logic       eb [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [7:0] od;
      logic       ob, oo;
      int         lat;
      for (int i = 0; i < 4; i++) begin
         do_op(va[i], vb[i], od, ob, oo, lat);
         checks++;
         if (lat !== W) begin
            errors++;
            $display("FAIL edge_latency[%0d]: %0d edges, want %0d", i, lat, W);
         end
         checks++;
         if ({od, ob, oo} !== {ed[i], eb[i], eo[i]}) begin
            errors++;
            $display("FAIL edge_result[%0d] %h-%h: got %h/%b/%b, want %h/%b/%b", i, va[i],
                     vb[i], od, ob, oo, ed[i], eb[i], eo[i]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int lat;
      int gap;
      int unstable;
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h01;
      @(posedge clk); #1;
      a   = 8'h99;
      b   = 8'h11;
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if ({done, diff} !== {1'b1, 8'h0F}) begin
         errors++;
         $display("FAIL busy_first: done=%b diff=%h, want 1 0f", done, diff);
      end
      gap      = 0;
      unstable = 0;
      do begin
         @(posedge clk); #1;
         gap++;
         if (!done && diff !== 8'h0F) unstable++;
      end while (!done && gap < 40);
      checks++;
      if (gap !== W + 2) begin
         errors++;
         $display("FAIL busy_gap: second done %0d cycles later, want %0d", gap, W + 2);
      end
      checks++;
      if (unstable !== 0) begin
         errors++;
         $display("FAIL busy_stable: diff left 0f in %0d cycles, want 0", unstable);
      end
      checks++;
      if ({diff, borrow, ovf} !== {8'h88, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL busy_second: got %h/%b/%b, want 88/0/0", diff, borrow, ovf);
      end
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int         seen;
      logic [7:0] od;
      logic       ob, oo;
      int         lat;
      start = 1'b1;
      a     = 8'h5A;
      b     = 8'h3C;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, diff, borrow, ovf} !== 12'h000) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
                  busy, done, diff, borrow, ovf);
      end
      #2;
      rst_n = 1'b1;
      seen  = 0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL mid_no_done: %0d cycles busy/done after abort, want 0", seen);
      end
      do_op(8'h03, 8'h05, od, ob, oo, lat);
      checks++;
      if ({od, ob, oo} !== {8'hFE, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mid_fresh: got %h/%b/%b, want fe/1/0", od, ob, oo);
      end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb, ed, od;
      logic       eb, eo, ob, oo;
      int         lat;
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         ed = ra - rb;
         eb = (ra < rb);
         eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
         do_op(ra, rb, od, ob, oo, lat);
         checks++;
         if (lat !== W || {od, ob, oo} !== {ed, eb, eo}) begin
            errors++;
            $display("FAIL random[%0d] %h-%h: got %h/%b/%b lat %0d, want %h/%b/%b lat %0d",
                     i, ra, rb, od, ob, oo, lat, ed, eb, eo, W);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap_ovf();
      test_start_while_busy();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
